// File: rtl/perf_counter_master.sv
// Avalon-MM master that turns GO/STOP/RESET_ALL/SAMPLE commands into accesses on the
// 8-section performance-counter slave, returning a tear-free 64-bit time plus events.
module perf_counter_master #(
    parameter int READ_LATENCY = 1,
    parameter int MAX_RETRY    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_section,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_time,
    output logic [31:0] res_events,
    output logic        res_torn,
    output logic [4:0]  avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    // Handshakes: a command transfers on a rising edge with cmd_valid & cmd_ready, a result
    // with res_valid & res_ready; an Avalon request is taken on an edge with !avm_waitrequest.
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_HI0,
        S_RD_LO,
        S_RD_HI1,
        S_RD_EV,
        S_RESP
    } state_t;

    localparam logic [1:0] OP_GO        = 2'b00;
    localparam logic [1:0] OP_STOP      = 2'b01;
    localparam logic [1:0] OP_RESET_ALL = 2'b10;
    localparam logic [1:0] OP_SAMPLE    = 2'b11;

    localparam logic [1:0] LAT_LAST  = 2'(READ_LATENCY - 1);
    localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

    state_t      state_q, state_d;
    logic        waiting_q, waiting_d;
    logic [1:0]  lat_cnt_q, lat_cnt_d;
    logic [2:0]  retry_q, retry_d;
    logic [2:0]  section_q, section_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] hi0_q, hi0_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] res_time_q, res_time_d;
    logic [31:0] res_events_q, res_events_d;
    logic        res_torn_q, res_torn_d;
    logic        res_valid_q, res_valid_d;

    logic        is_rd;
    logic        rd_done;
    logic [1:0]  rd_offset;

    assign res_valid  = res_valid_q;
    assign res_time   = res_time_q;
    assign res_events = res_events_q;
    assign res_torn   = res_torn_q;

    always_comb begin
        state_d       = state_q;
        waiting_d     = waiting_q;
        lat_cnt_d     = lat_cnt_q;
        retry_d       = retry_q;
        section_d     = section_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        hi0_d         = hi0_q;
        lo_d          = lo_q;
        res_time_d    = res_time_q;
        res_events_d  = res_events_q;
        res_torn_d    = res_torn_q;
        res_valid_d   = res_valid_q;
        cmd_ready     = 1'b0;
        avm_address   = 5'd0;
        avm_write     = 1'b0;
        avm_read      = 1'b0;
        avm_writedata = 32'd0;

        is_rd = (state_q == S_RD_HI0) || (state_q == S_RD_LO) ||
                (state_q == S_RD_HI1) || (state_q == S_RD_EV);
        rd_done = is_rd && waiting_q && (lat_cnt_q == LAT_LAST);

        unique case (state_q)
            S_RD_LO: rd_offset = 2'd0;
            S_RD_EV: rd_offset = 2'd2;
            default: rd_offset = 2'd1;
        endcase

        // Shared request/wait phase sequencing for every read state.
        if (is_rd) begin
            if (!waiting_q) begin
                avm_read    = 1'b1;
                avm_address = {section_q, rd_offset};
                if (!avm_waitrequest) begin
                    waiting_d = 1'b1;
                    lat_cnt_d = 2'd0;
                end
            end else if (lat_cnt_q != LAT_LAST) begin
                lat_cnt_d = lat_cnt_q + 2'd1;
            end else begin
                waiting_d = 1'b0;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = !reset;
                if (cmd_valid && !reset) begin
                    section_d = cmd_section;
                    unique case (cmd_op)
                        OP_GO: begin
                            wr_addr_d = {cmd_section, 2'd1};
                            wr_data_d = 32'd0;
                            state_d   = S_WR;
                        end
                        OP_STOP: begin
                            wr_addr_d = {cmd_section, 2'd0};
                            wr_data_d = 32'd0;
                            state_d   = S_WR;
                        end
                        OP_RESET_ALL: begin
                            wr_addr_d = 5'd0;
                            wr_data_d = 32'd1;
                            state_d   = S_WR;
                        end
                        OP_SAMPLE: begin
                            retry_d    = 3'd0;
                            res_torn_d = 1'b0;
                            waiting_d  = 1'b0;
                            state_d    = S_RD_HI0;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_WR: begin
                avm_write     = 1'b1;
                avm_address   = wr_addr_q;
                avm_writedata = wr_data_q;
                if (!avm_waitrequest) begin
                    state_d = S_IDLE;
                end
            end
            S_RD_HI0: begin
                if (rd_done) begin
                    hi0_d   = avm_readdata;
                    state_d = S_RD_LO;
                end
            end
            S_RD_LO: begin
                if (rd_done) begin
                    lo_d    = avm_readdata;
                    state_d = S_RD_HI1;
                end
            end
            S_RD_HI1: begin
                // A matching high word brackets the low read, so {hi, lo} cannot be torn.
                if (rd_done) begin
                    if (avm_readdata == hi0_q) begin
                        res_time_d = {hi0_q, lo_q};
                        state_d    = S_RD_EV;
                    end else if (retry_q == RETRY_MAX) begin
                        res_time_d = {avm_readdata, lo_q};
                        res_torn_d = 1'b1;
                        state_d    = S_RD_EV;
                    end else begin
                        hi0_d   = avm_readdata;
                        retry_d = retry_q + 3'd1;
                        state_d = S_RD_LO;
                    end
                end
            end
            S_RD_EV: begin
                if (rd_done) begin
                    res_events_d = avm_readdata;
                    res_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    res_torn_d  = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            waiting_q    <= 1'b0;
            lat_cnt_q    <= 2'd0;
            retry_q      <= 3'd0;
            section_q    <= 3'd0;
            wr_addr_q    <= 5'd0;
            wr_data_q    <= 32'd0;
            hi0_q        <= 32'd0;
            lo_q         <= 32'd0;
            res_time_q   <= 64'd0;
            res_events_q <= 32'd0;
            res_torn_q   <= 1'b0;
            res_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            waiting_q    <= waiting_d;
            lat_cnt_q    <= lat_cnt_d;
            retry_q      <= retry_d;
            section_q    <= section_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            hi0_q        <= hi0_d;
            lo_q         <= lo_d;
            res_time_q   <= res_time_d;
            res_events_q <= res_events_d;
            res_torn_q   <= res_torn_d;
            res_valid_q  <= res_valid_d;
        end
    end

endmodule

// File: tb/tb_perf_counter_master.sv
// Directed bench for perf_counter_master with a behavioural counter slave (read latency 1).
module tb_perf_counter_master;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_section;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_time;
    logic [31:0] res_events;
    logic        res_torn;
    logic [4:0]  avm_address;
    logic        avm_write;
    logic        avm_read;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave model state: mode 0 fixed high word, 1 steps once after first high read,
    // 2 steps on every high read.
    int          m_mode;
    logic [31:0] m_hi, m_lo, m_ev;
    int          hi_reads = 0;
    int          hi_start;
    logic [4:0]  rd_addr_log [0:63];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [4:0]  wr_last_addr;
    logic [31:0] wr_last_data;
    int          bus_viol = 0;
    logic        prev_stall = 1'b0;
    logic [4:0]  prev_addr = 5'd0;

    perf_counter_master #(.READ_LATENCY(1), .MAX_RETRY(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_section     (cmd_section),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_time        (res_time),
        .res_events      (res_events),
        .res_torn        (res_torn),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_read        (avm_read),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] hi_value(input int mode, input int idx, input logic [31:0] base);
        if (mode == 1) return (idx == 0) ? base : base + 32'd1;
        if (mode == 2) return base + 32'(idx);
        return base;
    endfunction

    always @(posedge clk) begin
        if (avm_read && !avm_waitrequest) begin
            if (rd_cnt < 64) rd_addr_log[rd_cnt] <= avm_address;
            rd_cnt <= rd_cnt + 1;
            case (avm_address[1:0])
                2'd0: avm_readdata <= m_lo;
                2'd1: begin
                    avm_readdata <= hi_value(m_mode, hi_reads - hi_start, m_hi);
                    hi_reads <= hi_reads + 1;
                end
                2'd2: avm_readdata <= m_ev;
                default: avm_readdata <= 32'hDEAD_BEEF;
            endcase
        end
        if (avm_write && !avm_waitrequest) begin
            wr_cnt       <= wr_cnt + 1;
            wr_last_addr <= avm_address;
            wr_last_data <= avm_writedata;
        end
        if (avm_read && avm_write) bus_viol <= bus_viol + 1;
        if (prev_stall && !((avm_read || avm_write) && avm_address == prev_addr))
            bus_viol <= bus_viol + 1;
        prev_stall <= (avm_read || avm_write) && avm_waitrequest;
        prev_addr  <= avm_address;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a command at a falling edge and returns at the falling edge after acceptance.
    task automatic issue(input logic [1:0] op, input logic [2:0] sec);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_section = sec;
        check("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (!res_valid && n < 80) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(res_valid), 64'd1);
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_cleared", 64'(res_valid), 64'd0);
        check("res_torn_cleared", 64'(res_torn), 64'd0);
        check("cmd_ready_after_resp", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        int rd_start;
        int wr_start;
        int seen;
        logic [4:0] exp4 [0:5];
        logic [4:0] exp5 [0:11];
        logic [63:0] held_time;

        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'd0;
        cmd_section = 3'd0;
        res_ready = 1'b0;
        avm_waitrequest = 1'b0;
        m_mode = 0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        m_ev = 32'd0;
        hi_start = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_avm_rw", {62'd0, avm_read, avm_write}, 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_time", res_time, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // GO, section 3: single write at address 13, data 0
        wr_start = wr_cnt;
        issue(2'b00, 3'd3);
        check("go_write", 64'(avm_write), 64'd1);
        check("go_addr", 64'(avm_address), 64'd13);
        check("go_data", 64'(avm_writedata), 64'd0);
        check("go_busy", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        check("go_ready_back", 64'(cmd_ready), 64'd1);
        check("go_write_done", 64'(avm_write), 64'd0);
        check("go_wr_count", 64'(wr_cnt - wr_start), 64'd1);

        // RESET_ALL with section 5 ignored, slave stalls three edges
        wr_start = wr_cnt;
        avm_waitrequest = 1'b1;
        issue(2'b10, 3'd5);
        for (int i = 0; i < 4; i++) begin
            check("rall_write", 64'(avm_write), 64'd1);
            check("rall_addr", 64'(avm_address), 64'd0);
            check("rall_data", 64'(avm_writedata), 64'd1);
            if (i == 3) avm_waitrequest = 1'b0;
            @(negedge clk);
        end
        check("rall_ready_back", 64'(cmd_ready), 64'd1);
        check("rall_wr_count", 64'(wr_cnt - wr_start), 64'd1);
        check("rall_wr_addr", 64'(wr_last_addr), 64'd0);
        check("rall_wr_data", 64'(wr_last_data), 64'd1);

        // Clean SAMPLE, section 2: reads 9, 8, 9, 10; result 8 edges after acceptance
        m_mode = 0; m_hi = 32'h7; m_lo = 32'h1234; m_ev = 32'h55;
        hi_start = hi_reads;
        rd_start = rd_cnt;
        issue(2'b11, 3'd2);
        repeat (7) @(negedge clk);
        check("smp_no_valid_early", 64'(res_valid), 64'd0);
        @(negedge clk);
        check("smp_valid_at_8", 64'(res_valid), 64'd1);
        check("smp_time", res_time, 64'h0000_0007_0000_1234);
        check("smp_events", 64'(res_events), 64'h55);
        check("smp_torn", 64'(res_torn), 64'd0);
        check("smp_rd_count", 64'(rd_cnt - rd_start), 64'd4);
        check("smp_rd0", 64'(rd_addr_log[rd_start]), 64'd9);
        check("smp_rd1", 64'(rd_addr_log[rd_start + 1]), 64'd8);
        check("smp_rd2", 64'(rd_addr_log[rd_start + 2]), 64'd9);
        check("smp_rd3", 64'(rd_addr_log[rd_start + 3]), 64'd10);
        consume();

        // SAMPLE, section 1, high word moves 7 -> 8 between hi0 and hi1
        m_mode = 1; m_hi = 32'h7; m_lo = 32'h2; m_ev = 32'h99;
        hi_start = hi_reads;
        rd_start = rd_cnt;
        exp4[0] = 5'd5; exp4[1] = 5'd4; exp4[2] = 5'd5;
        exp4[3] = 5'd4; exp4[4] = 5'd5; exp4[5] = 5'd6;
        issue(2'b11, 3'd1);
        wait_result("retry_valid");
        check("retry_time", res_time, 64'h0000_0008_0000_0002);
        check("retry_events", 64'(res_events), 64'h99);
        check("retry_torn", 64'(res_torn), 64'd0);
        check("retry_rd_count", 64'(rd_cnt - rd_start), 64'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("retry_rd%0d", i), 64'(rd_addr_log[rd_start + i]), 64'(exp4[i]));
        consume();

        // SAMPLE, section 7, high word never settles: 4 retries then torn result
        m_mode = 2; m_hi = 32'h10; m_lo = 32'hABCD_0000; m_ev = 32'h77;
        hi_start = hi_reads;
        rd_start = rd_cnt;
        exp5[0] = 5'd29;
        for (int i = 0; i < 5; i++) begin
            exp5[1 + 2 * i] = 5'd28;
            exp5[2 + 2 * i] = 5'd29;
        end
        exp5[11] = 5'd30;
        issue(2'b11, 3'd7);
        wait_result("torn_valid");
        check("torn_time", res_time, 64'h0000_0015_ABCD_0000);
        check("torn_events", 64'(res_events), 64'h77);
        check("torn_flag", 64'(res_torn), 64'd1);
        check("torn_rd_count", 64'(rd_cnt - rd_start), 64'd12);
        for (int i = 0; i < 12; i++)
            check($sformatf("torn_rd%0d", i), 64'(rd_addr_log[rd_start + i]), 64'(exp5[i]));
        held_time = res_time;
        wr_start = wr_cnt;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_section = 3'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_time", res_time, held_time);
            check("hold_torn", 64'(res_torn), 64'd1);
            check("hold_no_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        cmd_valid = 1'b0;
        check("hold_no_write", 64'(wr_cnt - wr_start), 64'd0);
        consume();

        // Reset during the RD_LO latency wait aborts the sample
        m_mode = 0; m_hi = 32'h1; m_lo = 32'h2; m_ev = 32'h3;
        hi_start = hi_reads;
        rd_start = rd_cnt;
        issue(2'b11, 3'd0);
        repeat (3) @(negedge clk);
        check("abort_in_lo_wait", 64'(rd_cnt - rd_start), 64'd2);
        check("abort_no_req_in_wait", 64'(avm_read), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_avm_rw", {62'd0, avm_read, avm_write}, 64'd0);
        check("abort_avm_addr", 64'(avm_address), 64'd0);
        check("abort_avm_wdata", 64'(avm_writedata), 64'd0);
        check("abort_res_valid", 64'(res_valid), 64'd0);
        check("abort_cmd_ready", 64'(cmd_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready_back", 64'(cmd_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        check("abort_no_result", 64'(seen), 64'd0);
        check("abort_no_more_reads", 64'(rd_cnt - rd_start), 64'd2);

        check("bus_rules", 64'(bus_viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
